// File: rtl/arb_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM encoding,
// requester IDs and default port widths.
package arb_pkg;

  localparam int DEF_ADDR_W = 28;
  localparam int DEF_DATA_W = 128;

  // Requester IDs double as the bit index into the arbitration mask.
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between the I and D requesters.
// ARB_RR_EN selects round robin on ties; otherwise the data side wins ties.
module arb_pick
  import arb_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  logic [1:0] mask,
  input  logic       last_grant,
  output logic       valid,
  output logic       winner
);

  logic i_ok, d_ok;

  assign i_ok  = i_req & ~mask[REQ_I];
  assign d_ok  = d_req & ~mask[REQ_D];
  assign valid = i_ok | d_ok;

`ifdef ARB_RR_EN
  always_comb begin
    winner = REQ_D;
    if (i_ok && d_ok) winner = ~last_grant;
    else if (i_ok)    winner = REQ_I;
  end
`else
  // last_grant is kept for interface symmetry; fixed priority ignores it.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    winner = REQ_D;
    if (i_ok && !d_ok) winner = REQ_I;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line memory port between the I- and D-cache wrappers; the memory
// request is registered and ready/rdata route back to the granted side only.
// Optional macro ARB_RR_EN enables round-robin tie breaking.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_t            state, state_nxt;
  logic              grant, last_grant;
  logic [DATA_W-1:0] hold_i, hold_d;

  logic              i_req, d_req, pick_valid, winner, load, done_busy;
  logic [1:0]        mask;
  logic              sel_rd, sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign i_req = i_mem_read | i_mem_write;
  assign d_req = d_mem_read | d_mem_write;

  // The requester just served is dropping or changing its request in DONE.
  assign mask = (state == DONE) ? (2'b01 << grant) : 2'b00;

  arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .mask       (mask),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (winner)
  );

  assign sel_rd    = (winner == REQ_D) ? d_mem_read  : i_mem_read;
  assign sel_wr    = (winner == REQ_D) ? d_mem_write : i_mem_write;
  assign sel_addr  = (winner == REQ_D) ? d_mem_addr  : i_mem_addr;
  assign sel_wdata = (winner == REQ_D) ? d_mem_wdata : i_mem_wdata;

  assign load      = pick_valid & ((state == IDLE) | (state == DONE));
  assign done_busy = (state == BUSY) & mem_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = BUSY;
      BUSY:    if (mem_ready)  state_nxt = DONE;
      DONE:    state_nxt = pick_valid ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign i_mem_ready = done_busy & (grant == REQ_I);
  assign d_mem_ready = done_busy & (grant == REQ_D);
  assign i_mem_rdata = i_mem_ready ? mem_rdata : hold_i;
  assign d_mem_rdata = d_mem_ready ? mem_rdata : hold_d;

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state      <= IDLE;
      grant      <= REQ_D;
      last_grant <= REQ_D;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hold_i     <= '0;
      hold_d     <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        grant      <= winner;
        last_grant <= winner;
        // Read and write together is illegal; the read wins.
        mem_read   <= sel_rd;
        mem_write  <= sel_wr & ~sel_rd;
        mem_addr   <= sel_addr;
        mem_wdata  <= sel_wdata;
      end else if (done_busy) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
      end
      if (i_mem_ready) hold_i <= mem_rdata;
      if (d_mem_ready) hold_d <= mem_rdata;
    end
  end

endmodule
